pebble_minimax_engine: RTL and testbench

PEBBLE_MINIMAX_ENGINE -- requirements
Module: pebble_minimax_engine

---
 rtl/pebble_minimax_engine.sv | 219 +++++++++++++++++++++
 tb/tb_pebble_minimax_engine.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pebble_minimax_engine.sv
// Two-player pebble-sowing game engine with a computer opponent picking moves by exhaustive search.
// Define PEBBLE_LOOKAHEAD2_EN for two-ply minimax; otherwise moves are scored by one-ply lookahead.
module pebble_minimax_engine #(
    parameter int unsigned PITS        = 2,
    parameter int unsigned INIT_STONES = 2,
    localparam int unsigned TOTAL      = 2 * PITS * INIT_STONES,
    localparam int unsigned W          = $clog2(TOTAL + 1),
    localparam int unsigned IW         = $clog2(PITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  move_valid,
    input  logic [IW-1:0]         move_pit,
    output logic                  move_ready,
    output logic [2*PITS*W-1:0]   board,
    output logic                  ai_busy,
    output logic                  ai_move_valid,
    output logic [IW-1:0]         ai_move_pit,
    output logic                  illegal_move,
    output logic                  game_over,
    output logic [1:0]            winner
);

    localparam int unsigned N  = 2 * PITS;
    localparam int unsigned KW = $clog2(N);

    typedef logic [N-1:0][W-1:0] board_t;
    typedef enum logic [2:0] {StIdle, StPlayer, StCheck, StSearch, StApply, StOver} state_e;

    localparam board_t InitBoard = {N{W'(INIT_STONES)}};

    // Closed-form sowing: full laps go everywhere, the remainder to the pits following k.
    function automatic board_t sow(input board_t b, input logic [KW-1:0] k);
        board_t      r;
        int unsigned s, q, m, d;
        s = 32'(b[k]);
        q = s / N;
        m = s % N;
        for (int unsigned j = 0; j < N; j++) begin
            d = (j + N - 32'(k) - 1) % N;
            if (KW'(j) == k) r[KW'(j)] = W'(q);
            else r[KW'(j)] = W'(32'(b[KW'(j)]) + q + ((d < m) ? 32'd1 : 32'd0));
        end
        return r;
    endfunction

    function automatic logic [W-1:0] comp_sum(input board_t b);
        int unsigned acc;
        acc = 0;
        for (int unsigned j = 0; j < PITS; j++) acc += 32'(b[KW'(j)]);
        return W'(acc);
    endfunction

    state_e          state_q, state_d;
    board_t          board_q, board_d;
    logic [1:0]      winner_q, winner_d;
    logic [IW-1:0]   ai_move_pit_q, ai_move_pit_d;
    logic            ai_move_valid_q, ai_move_valid_d;
    logic            illegal_q, illegal_d;
    logic            from_apply_q, from_apply_d;
    logic [IW-1:0]   si_q, si_d;
    logic [W-1:0]    best_q, best_d;
    logic [IW-1:0]   best_pit_q, best_pit_d;
    logic            best_valid_q, best_valid_d;

    board_t          b1;
    logic [W-1:0]    cs1, psum, score;
    logic            move_ok, last_j;
    logic [KW-1:0]   pidx;

`ifdef PEBBLE_LOOKAHEAD2_EN
    logic [IW-1:0]   sj_q, sj_d;
    logic [W-1:0]    min_q, min_d;
    board_t          b2;
    logic [W-1:0]    leaf, cur_min;
    logic            reply_ok;
`endif

    always_comb begin
        state_d         = state_q;
        board_d         = board_q;
        winner_d        = winner_q;
        ai_move_pit_d   = ai_move_pit_q;
        ai_move_valid_d = 1'b0;
        illegal_d       = illegal_q;
        from_apply_d    = from_apply_q;
        si_d            = si_q;
        best_d          = best_q;
        best_pit_d      = best_pit_q;
        best_valid_d    = best_valid_q;

        pidx    = KW'(PITS) + KW'(move_pit);
        psum    = comp_sum(board_q);
        b1      = sow(board_q, KW'(si_q));
        cs1     = comp_sum(b1);
        move_ok = (board_q[KW'(si_q)] != '0);

`ifdef PEBBLE_LOOKAHEAD2_EN
        sj_d     = sj_q;
        min_d    = min_q;
        b2       = sow(b1, KW'(PITS) + KW'(sj_q));
        reply_ok = (b1[KW'(PITS) + KW'(sj_q)] != '0);
        leaf     = comp_sum(b2);
        cur_min  = (sj_q == '0) ? W'(TOTAL) : min_q;
        if (reply_ok && (leaf < cur_min)) cur_min = leaf;
        // A move that ends the game is scored by its outcome, not by replies.
        if (cs1 == W'(TOTAL)) score = W'(TOTAL);
        else if (cs1 == '0)   score = '0;
        else                  score = cur_min;
        last_j = (sj_q == IW'(PITS - 1));
`else
        score  = cs1;
        last_j = 1'b1;
`endif

        unique case (state_q)
            StIdle: begin
                if (move_valid) begin
                    // Sowing an empty pit is a no-op, so the board may be written unconditionally.
                    board_d      = sow(board_q, pidx);
                    illegal_d    = (board_q[pidx] == '0);
                    from_apply_d = 1'b0;
                    state_d      = StPlayer;
                end
            end
            StPlayer: state_d = illegal_q ? StIdle : StCheck;
            StCheck: begin
                if (psum == '0) begin
                    winner_d = 2'b10;
                    state_d  = StOver;
                end else if (psum == W'(TOTAL)) begin
                    winner_d = 2'b01;
                    state_d  = StOver;
                end else if (from_apply_q) begin
                    state_d = StIdle;
                end else begin
                    si_d         = '0;
                    best_valid_d = 1'b0;
`ifdef PEBBLE_LOOKAHEAD2_EN
                    sj_d         = '0;
`endif
                    state_d      = StSearch;
                end
            end
            StSearch: begin
                if (last_j) begin
                    if (move_ok && (!best_valid_q || (score > best_q))) begin
                        best_d       = score;
                        best_pit_d   = si_q;
                        best_valid_d = 1'b1;
                    end
                    if (si_q == IW'(PITS - 1)) state_d = StApply;
                    else si_d = si_q + 1'b1;
`ifdef PEBBLE_LOOKAHEAD2_EN
                    sj_d = '0;
                end else begin
                    sj_d  = sj_q + 1'b1;
                    min_d = cur_min;
`endif
                end
            end
            StApply: begin
                board_d         = sow(board_q, KW'(best_pit_q));
                ai_move_pit_d   = best_pit_q;
                ai_move_valid_d = 1'b1;
                from_apply_d    = 1'b1;
                state_d         = StCheck;
            end
            StOver:  state_d = StOver;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= StIdle;
            board_q         <= InitBoard;
            winner_q        <= 2'b00;
            ai_move_pit_q   <= '0;
            ai_move_valid_q <= 1'b0;
            illegal_q       <= 1'b0;
            from_apply_q    <= 1'b0;
            si_q            <= '0;
            best_q          <= '0;
            best_pit_q      <= '0;
            best_valid_q    <= 1'b0;
`ifdef PEBBLE_LOOKAHEAD2_EN
            sj_q            <= '0;
            min_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            board_q         <= board_d;
            winner_q        <= winner_d;
            ai_move_pit_q   <= ai_move_pit_d;
            ai_move_valid_q <= ai_move_valid_d;
            illegal_q       <= illegal_d;
            from_apply_q    <= from_apply_d;
            si_q            <= si_d;
            best_q          <= best_d;
            best_pit_q      <= best_pit_d;
            best_valid_q    <= best_valid_d;
`ifdef PEBBLE_LOOKAHEAD2_EN
            sj_q            <= sj_d;
            min_q           <= min_d;
`endif
        end
    end

    assign board         = board_q;
    assign move_ready    = (state_q == StIdle);
    assign ai_busy       = (state_q == StSearch);
    assign ai_move_valid = ai_move_valid_q;
    assign ai_move_pit   = ai_move_pit_q;
    assign illegal_move  = (state_q == StPlayer) && illegal_q;
    assign game_over     = (state_q == StOver);
    assign winner        = winner_q;

endmodule

// File: tb/tb_pebble_minimax_engine.sv
// Self-checking bench for pebble_minimax_engine: directed vectors plus random games
// scored against a stone-by-stone game model.
module tb_pebble_minimax_engine;

    localparam int PITS  = 2;
    localparam int INIT  = 2;
    localparam int NP    = 2 * PITS;
    localparam int TOTAL = NP * INIT;
    localparam int W     = 4;
    localparam int IW    = 1;
`ifdef PEBBLE_LOOKAHEAD2_EN
    localparam int SEARCH_CYC = PITS * PITS;
`else
    localparam int SEARCH_CYC = PITS;
`endif

    logic              clock, reset, move_valid;
    logic [IW-1:0]     move_pit;
    logic              move_ready, ai_busy, ai_move_valid, illegal_move, game_over;
    logic [NP*W-1:0]   board;
    logic [IW-1:0]     ai_move_pit;
    logic [1:0]        winner;

    pebble_minimax_engine #(.PITS(PITS), .INIT_STONES(INIT)) dut (
        .clock        (clock),
        .reset        (reset),
        .move_valid   (move_valid),
        .move_pit     (move_pit),
        .move_ready   (move_ready),
        .board        (board),
        .ai_busy      (ai_busy),
        .ai_move_valid(ai_move_valid),
        .ai_move_pit  (ai_move_pit),
        .illegal_move (illegal_move),
        .game_over    (game_over),
        .winner       (winner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef logic [NP-1:0][7:0] brd_t;

    int   checks   = 0;
    int   failures = 0;
    brd_t mb;
    bit   over;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drop stones one at a time into successive pits, wrapping round the ring.
    function automatic brd_t m_sow(input brd_t b, input int k);
        int s, pos;
        s = int'(b[k]);
        b[k] = 8'd0;
        pos = k;
        while (s > 0) begin
            pos = (pos + 1) % NP;
            b[pos] = b[pos] + 8'd1;
            s--;
        end
        return b;
    endfunction

    function automatic int m_comp(input brd_t b);
        int acc;
        acc = 0;
        for (int i = 0; i < PITS; i++) acc += int'(b[i]);
        return acc;
    endfunction

    function automatic logic [31:0] m_pack(input brd_t b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*W +: W] = b[i][W-1:0];
        return r;
    endfunction

    function automatic int m_winner(input brd_t b);
        if (m_comp(b) == 0) return 2;
        if (m_comp(b) == TOTAL) return 1;
        return 0;
    endfunction

    function automatic int m_choose(input brd_t b);
        brd_t b1;
        int   best, pick, sc, mn, v;
        best = -1;
        pick = 0;
        for (int i = 0; i < PITS; i++) begin
            if (b[i] == 0) continue;
            b1 = m_sow(b, i);
            sc = m_comp(b1);
`ifdef PEBBLE_LOOKAHEAD2_EN
            if (sc != 0 && sc != TOTAL) begin
                mn = TOTAL + 1;
                for (int j = 0; j < PITS; j++) begin
                    if (b1[PITS + j] == 0) continue;
                    v = m_comp(m_sow(b1, PITS + j));
                    if (v < mn) mn = v;
                end
                sc = mn;
            end
`endif
            if (sc > best) begin
                best = sc;
                pick = i;
            end
        end
        return pick;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        move_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < NP; i++) mb[i] = 8'(INIT);
        over = 1'b0;
        check("reset_board", m_pack(mb), 32'(board));
        check("reset_winner", 32'(winner), 32'd0);
        check("reset_ready", 32'(move_ready), 32'd1);
        check("reset_busy", 32'(ai_busy), 32'd0);
        check("reset_over", 32'(game_over), 32'd0);
        check("reset_ai_pit", 32'(ai_move_pit), 32'd0);
        check("reset_pulses", 32'({ai_move_valid, illegal_move}), 32'd0);
    endtask

    // Plays one player move (from IDLE) and the computer reply, checking each step.
    task automatic do_move(input int p, input bit hold, output logic [31:0] ob_pl,
                           output logic [31:0] ob_ai, output logic [31:0] opit,
                           output logic [31:0] oill);
        int n, busy, cs, exp_pit;
        bit legal;
        check("ready_before_move", 32'(move_ready), 32'd1);
        move_valid = 1'b1;
        move_pit   = IW'(p);
        @(posedge clock);
        @(negedge clock);
        if (!hold) move_valid = 1'b0;
        ob_pl = 32'(board);
        ob_ai = 32'(board);
        opit  = 32'(ai_move_pit);
        oill  = 32'(illegal_move);
        legal = (mb[PITS + p] != 0);
        check("illegal_pulse", 32'(illegal_move), 32'(!legal));
        if (!legal) begin
            check("illegal_board", 32'(board), m_pack(mb));
            @(negedge clock);
            move_valid = 1'b0;
            check("ready_after_illegal", 32'(move_ready), 32'd1);
            check("illegal_one_cycle", 32'(illegal_move), 32'd0);
            return;
        end
        mb = m_sow(mb, PITS + p);
        check("player_board", 32'(board), m_pack(mb));
        cs = m_comp(mb);
        if (cs == 0 || cs == TOTAL) begin
            @(negedge clock);
            @(negedge clock);
            move_valid = 1'b0;
            check("over_after_player", 32'(game_over), 32'd1);
            check("winner_after_player", 32'(winner), 32'(m_winner(mb)));
            over = 1'b1;
            return;
        end
        exp_pit = m_choose(mb);
        busy = 0;
        n = 0;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (ai_move_valid) break;
            if (ai_busy) busy++;
        end
        move_valid = 1'b0;
        check("ai_pulse_seen", 32'(ai_move_valid), 32'd1);
        check("ai_busy_cycles", 32'(busy), 32'(SEARCH_CYC));
        check("ai_pit", 32'(ai_move_pit), 32'(exp_pit));
        mb = m_sow(mb, exp_pit);
        check("ai_board", 32'(board), m_pack(mb));
        opit  = 32'(ai_move_pit);
        ob_ai = 32'(board);
        @(negedge clock);
        check("ai_pulse_one_cycle", 32'(ai_move_valid), 32'd0);
        if (m_winner(mb) != 0) begin
            check("over_after_ai", 32'(game_over), 32'd1);
            check("winner_after_ai", 32'(winner), 32'(m_winner(mb)));
            over = 1'b1;
        end else begin
            check("ready_after_ai", 32'(move_ready), 32'd1);
        end
    endtask

    typedef struct {
        int          pit;
        logic [31:0] pl;
        logic [31:0] ai;
        logic [31:0] aipit;
        logic [31:0] ill;
    } vec_t;

    vec_t        tbl[4];
    logic [31:0] o_pl, o_ai, o_pit, o_ill;
    logic [31:0] frozen;
    int          n;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Player always sows pit 0; boards are nibbles pit3..pit0.
        tbl[0] = '{pit: 0, pl: 32'h3023, ai: 32'h4130, aipit: 32'd0, ill: 32'd0};
        tbl[1] = '{pit: 0, pl: 32'h5030, ai: 32'h6101, aipit: 32'd1, ill: 32'd0};
        tbl[2] = '{pit: 0, pl: 32'h7001, ai: 32'h7010, aipit: 32'd0, ill: 32'd0};
        tbl[3] = '{pit: 0, pl: 32'h7010, ai: 32'h7010, aipit: 32'd0, ill: 32'd1};

        reset = 1'b0;
        move_valid = 1'b0;
        move_pit = '0;
        do_reset();

        for (int v = 0; v < 4; v++) begin
            do_move(tbl[v].pit, 1'b0, o_pl, o_ai, o_pit, o_ill);
            check($sformatf("vec%0d_player_board", v), o_pl, tbl[v].pl);
            check($sformatf("vec%0d_ai_board", v), o_ai, tbl[v].ai);
            check($sformatf("vec%0d_ai_pit", v), o_pit, tbl[v].aipit);
            check($sformatf("vec%0d_illegal", v), o_ill, tbl[v].ill);
        end

        // move_valid held through the search must not be taken as a second move.
        do_reset();
        do_move(0, 1'b1, o_pl, o_ai, o_pit, o_ill);
        check("hold_ai_board", o_ai, 32'h4130);
        check("hold_ai_pit", o_pit, 32'd0);

        // Reset on the second search cycle aborts cleanly.
        do_reset();
        move_valid = 1'b1;
        move_pit = '0;
        @(posedge clock);
        @(negedge clock);
        move_valid = 1'b0;
        n = 0;
        while (!ai_busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("abort_busy_seen", 32'(ai_busy), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check("abort_board", 32'(board), 32'h2222);
        check("abort_busy", 32'(ai_busy), 32'd0);
        check("abort_ready", 32'(move_ready), 32'd1);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (ai_move_valid) n++;
            @(negedge clock);
        end
        check("abort_no_ai_pulse", 32'(n), 32'd0);
        for (int i = 0; i < NP; i++) mb[i] = 8'(INIT);

        // Random games against the model.
        for (int g = 0; g < 12; g++) begin
            do_reset();
            for (int m = 0; m < 40 && !over; m++)
                do_move(int'($urandom_range(PITS - 1, 0)), 1'b0, o_pl, o_ai, o_pit, o_ill);
            if (over) begin
                frozen = 32'(board);
                move_valid = 1'b1;
                move_pit = '0;
                repeat (3) @(negedge clock);
                move_valid = 1'b0;
                check("over_sticky", 32'(game_over), 32'd1);
                check("over_not_ready", 32'(move_ready), 32'd0);
                check("over_board_frozen", 32'(board), frozen);
                check("over_winner_held", 32'(winner), 32'(m_winner(mb)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
